// File: rtl/filter_mac_seq_if.sv
// Handshake and data bundle between the filter MAC sequencer and its environment.
// The slave side is the sequencer. The master side drives start, uk and the coefficient ROM.
interface filter_mac_seq_if #(
  parameter int N  = 25,
  parameter int AW = 2
);
  logic          start;
  logic [N-1:0]  uk;
  logic [N-1:0]  coef;
  logic [AW-1:0] coef_addr;
  logic [1:0]    sel;
  logic          busy;
  logic          done;
  logic [N-1:0]  yk;

  modport master (
    output start, uk, coef,
    input  coef_addr, sel, busy, done, yk
  );

  modport slave (
    input  start, uk, coef,
    output coef_addr, sel, busy, done, yk
  );
endinterface

// File: rtl/filter_mac_seq.sv
// Sequencer and accumulator for a TAPS-deep filter MAC. Each accepted start shifts uk into
// the delay line, sums saturated coef*x products and presents the saturated result on yk with done.
module filter_mac_seq #(
  parameter int N    = 25,
  parameter int Q    = 10,
  parameter int TAPS = 3,
  parameter int AW   = 2
) (
  input logic             clk,
  input logic             reset,
  filter_mac_seq_if.slave bus
);

  localparam int G    = $clog2(TAPS) + 1;
  localparam int ACCW = N + G;

  localparam logic [N-1:0] MAXN = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  state_t           state;
  state_t           nextState;
  logic [N-1:0]     delayLine [TAPS];
  logic [AW-1:0]    cnt;
  logic [ACCW-1:0]  acc;
  logic [N-1:0]     ykReg;
  logic             doneReg;
  logic             busyReg;

  logic [1:0]       selC;
  logic [AW-1:0]    coefAddrC;
  logic [N-1:0]     tapSample;
  logic signed [2*N-1:0] coefExt;
  logic signed [2*N-1:0] tapExt;
  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] shifted;
  logic [N-1:0]     p;
  logic [ACCW-1:0]  accSum;
  logic [N-1:0]     accSat;

  always_comb begin
    nextState = state;
    selC      = 2'd0;
    coefAddrC = '0;
    case (state)
      IDLE: if (bus.start) nextState = LOAD;
      LOAD: nextState = MAC;
      MAC: begin
        selC      = 2'd2;
        coefAddrC = cnt;
        if (cnt == AW'(TAPS - 1)) nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Product is floored by Q and clamped to N bits before it joins the guard-bit accumulator.
  always_comb begin
    tapSample = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (cnt == AW'(i)) tapSample = delayLine[i];
    end
    coefExt = {{N{bus.coef[N-1]}}, bus.coef};
    tapExt  = {{N{tapSample[N-1]}}, tapSample};
    prod    = coefExt * tapExt;
    shifted = prod >>> Q;
    if ((&shifted[2*N-1:N-1]) || (~|shifted[2*N-1:N-1])) p = shifted[N-1:0];
    else p = shifted[2*N-1] ? MINN : MAXN;
    accSum = acc + {{G{p[N-1]}}, p};
    if ((&acc[ACCW-1:N-1]) || (~|acc[ACCW-1:N-1])) accSat = acc[N-1:0];
    else accSat = acc[ACCW-1] ? MINN : MAXN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      ykReg   <= '0;
      doneReg <= 1'b0;
      busyReg <= 1'b0;
      for (int k = 0; k < TAPS; k++) delayLine[k] <= '0;
    end else begin
      state   <= nextState;
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          // A start held through the done cycle is accepted at its closing edge.
          busyReg <= bus.start;
          if (bus.start) begin
            for (int k = TAPS - 1; k > 0; k--) delayLine[k] <= delayLine[k-1];
            delayLine[0] <= bus.uk;
          end
        end
        LOAD: begin
          acc <= '0;
          cnt <= '0;
        end
        MAC: begin
          acc <= accSum;
          cnt <= cnt + AW'(1);
        end
        DONE: begin
          ykReg   <= accSat;
          doneReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.sel       = selC;
  assign bus.coef_addr = coefAddrC;
  assign bus.done      = doneReg;
  assign bus.busy      = busyReg;
  assign bus.yk        = ykReg;

endmodule

// File: tb/tb_filter_mac_seq.sv
// Directed bench for filter_mac_seq: a vector table of hand-computed outputs plus
// hand-written sequences for timing, ignored starts and mid-sample reset.
module tb_filter_mac_seq;

  localparam int N    = 25;
  localparam int Q    = 10;
  localparam int TAPS = 3;
  localparam int AW   = 2;
  localparam int MAXV = 16777215;
  localparam int MINV = -16777216;

  typedef struct {
    int uk;
    int c0;
    int c1;
    int c2;
    int expYk;
  } vecT;

  logic clk;
  logic reset;
  logic [N-1:0] coefTab [4];
  int checks;
  int failures;
  vecT vecs [12];

  filter_mac_seq_if #(.N(N), .AW(AW)) bus ();

  filter_mac_seq #(.N(N), .Q(Q), .TAPS(TAPS), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.coef = coefTab[bus.coef_addr];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setCoefs(input int c0, input int c1, input int c2);
    coefTab[0] = N'(c0);
    coefTab[1] = N'(c1);
    coefTab[2] = N'(c2);
    coefTab[3] = '0;
  endtask

  task automatic applyStimulus(input int ukVal, input int c0, input int c1, input int c2,
                               input int expYk, input string name);
    int lat;
    setCoefs(c0, c1, c2);
    bus.uk    = N'(ukVal);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({name, " latency"}, lat, 5);
    checkOutput({name, " yk"}, $signed(bus.yk), expYk);
  endtask

  task automatic pulseReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic countDones(input int cycles, output int n, output logic signed [N-1:0] lastYk);
    n = 0;
    lastYk = '0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (bus.done) begin
        n++;
        lastYk = $signed(bus.yk);
      end
    end
  endtask

  initial begin
    int expSel [6];
    int expAddr [6];
    int expDone [6];
    int n;
    logic signed [N-1:0] seenYk;

    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.uk    = '0;
    setCoefs(0, 0, 0);

    vecs[0]  = '{1, 1024, 1024, 1024, 1};
    vecs[1]  = '{2, 1024, 1024, 1024, 3};
    vecs[2]  = '{3, 1024, 1024, 1024, 6};
    vecs[3]  = '{MAXV, 1024, 1024, 1024, MAXV};
    vecs[4]  = '{MAXV, 1024, 1024, 1024, MAXV};
    vecs[5]  = '{MAXV, 1024, 1024, 1024, MAXV};
    vecs[6]  = '{MINV, 1024, 1024, 1024, 16777214};
    vecs[7]  = '{MINV, 1024, 1024, 1024, MINV};
    vecs[8]  = '{MINV, 1024, 1024, 1024, MINV};
    vecs[9]  = '{4, 512, -1024, 2048, 1};
    vecs[10] = '{3, -1, 0, 0, -1};
    vecs[11] = '{-3, 1536, 1024, 0, -2};

    // Reset state
    @(posedge clk);
    tick();
    reset = 1'b0;
    checkOutput("reset yk", $signed(bus.yk), 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset sel", bus.sel, 0);
    checkOutput("reset coef_addr", bus.coef_addr, 0);

    // Cycle-by-cycle timing of one sample
    expSel  = '{0, 2, 2, 2, 0, 0};
    expAddr = '{0, 0, 1, 2, 0, 0};
    expDone = '{0, 0, 0, 0, 0, 1};
    setCoefs(1024, 0, 0);
    bus.uk    = N'(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("timing c%0d sel", c), bus.sel, expSel[c]);
      checkOutput($sformatf("timing c%0d coef_addr", c), bus.coef_addr, expAddr[c]);
      checkOutput($sformatf("timing c%0d done", c), bus.done, expDone[c]);
      checkOutput($sformatf("timing c%0d busy", c), bus.busy, 1);
      if (c < 5) tick();
    end
    checkOutput("timing yk", $signed(bus.yk), 5);
    tick();
    checkOutput("timing done after", bus.done, 0);
    checkOutput("timing busy after", bus.busy, 0);

    pulseReset(1);

    // Back-to-back table vectors, delay line carries across entries
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].uk, vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].expYk,
                    $sformatf("vec%0d", i));
    end

    // Start pulsed during MAC must be ignored
    setCoefs(1024, 1024, 1024);
    bus.uk    = N'(10);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.uk    = N'(99);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    countDones(10, n, seenYk);
    checkOutput("ignored start done count", n, 1);
    checkOutput("ignored start yk", seenYk, 10);
    checkOutput("ignored start busy idle", bus.busy, 0);
    applyStimulus(0, 0, 1024, 0, 10, "ignored start x1");

    // Reset during the second MAC cycle aborts the sample
    setCoefs(1024, 1024, 1024);
    bus.uk    = N'(50);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checkOutput("abort coef_addr", bus.coef_addr, 1);
    pulseReset(1);
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort sel", bus.sel, 0);
    checkOutput("abort yk", $signed(bus.yk), 0);
    countDones(8, n, seenYk);
    checkOutput("abort done count", n, 0);
    applyStimulus(7, 1024, 1024, 1024, 7, "after abort");

    // Reset and start together: reset wins
    bus.uk    = N'(33);
    bus.start = 1'b1;
    reset     = 1'b1;
    tick();
    bus.start = 1'b0;
    reset     = 1'b0;
    checkOutput("reset+start busy", bus.busy, 0);
    countDones(6, n, seenYk);
    checkOutput("reset+start done count", n, 0);
    applyStimulus(1, 1024, 1024, 1024, 1, "after reset+start");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
